// File: rtl/buyruk_getirici.sv
// Instruction fetch front-end: owns the fetch PC, issues word-aligned memory
// requests (one outstanding at most), buffers the returned word and hands it
// to the instruction queue together with its PC. Redirects become a one-cycle
// jump pulse and flush whatever is still in flight.
module buyruk_getirici #(
    parameter logic [31:0] RESET_PS = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        atlama_gecerli_i,
    input  logic [31:0] atlama_ps_i,
    input  logic        durdur_i,
    input  logic        ps_durdur_i,
    input  logic        ps_iki_artir_i,
    output logic        bellek_istek_o,
    output logic [31:0] bellek_adres_o,
    input  logic        bellek_hazir_i,
    input  logic        bellek_veri_gecerli_i,
    input  logic [31:0] bellek_veri_i,
    output logic        kuyruk_aktif_o,
    output logic        ps_atladi_o,
    output logic [31:0] ps_o,
    output logic [31:0] buyruk_o
);

    typedef enum logic [2:0] {ATLA, ISTEK, BEKLE, SUN, IPTAL} durum_t;

    durum_t      durum_r, durum_d;
    logic [31:0] adres_r;    // word address of the word being fetched/held
    logic [31:0] hedef_r;    // pending redirect target, bit 0 always clear
    logic [31:0] tampon_r;   // single-entry response buffer
    logic        bosluk_r;   // forced empty slot after a compressed-tail delivery
    logic        yanlis_r;   // next delivery starts at the upper halfword

    logic        teslim;
    logic        istek_c;
    logic [31:0] adres_c;
    logic        aktif_c;
    logic        atladi_c;
    logic [31:0] ps_c;
    logic [31:0] buyruk_c;

    // Delivery flags the upper half as consumed on its own, so the queue's
    // PC+2 strobe and the ignored target bit 0 carry no extra information.
    logic unused_ok;
    assign unused_ok = ^{atlama_ps_i[0], ps_iki_artir_i};

    // A buffered word leaves only when the backend is free, no drain slot is
    // pending and no redirect is arriving in the same cycle.
    assign teslim = (durum_r == SUN) && !durdur_i && !bosluk_r && !atlama_gecerli_i;

    // Next-state and datapath outputs; redirect outranks every other event.
    always_comb begin
        durum_d  = durum_r;
        istek_c  = 1'b0;
        adres_c  = adres_r;
        aktif_c  = 1'b0;
        atladi_c = 1'b0;
        ps_c     = '0;
        buyruk_c = '0;
        case (durum_r)
            ATLA: begin
                atladi_c = 1'b1;
                ps_c     = hedef_r;
                if (!atlama_gecerli_i) durum_d = ISTEK;
            end
            ISTEK: begin
                // The request stays up in the redirect cycle; if it gets
                // granted there, its data must still be swallowed.
                istek_c = 1'b1;
                if (bellek_hazir_i)        durum_d = atlama_gecerli_i ? IPTAL : BEKLE;
                else if (atlama_gecerli_i) durum_d = ATLA;
            end
            BEKLE: begin
                if (atlama_gecerli_i)           durum_d = bellek_veri_gecerli_i ? ATLA : IPTAL;
                else if (bellek_veri_gecerli_i) durum_d = SUN;
            end
            SUN: begin
                ps_c     = {adres_r[31:2], yanlis_r, 1'b0};
                buyruk_c = tampon_r;
                if (atlama_gecerli_i) begin
                    durum_d = ATLA;
                end else if (teslim) begin
                    // Buffer empties this cycle, so the next word is requested now.
                    aktif_c = 1'b1;
                    istek_c = 1'b1;
                    adres_c = adres_r + 32'd4;
                    durum_d = bellek_hazir_i ? BEKLE : ISTEK;
                end
            end
            IPTAL: begin
                if (bellek_veri_gecerli_i) durum_d = ATLA;
            end
            default: durum_d = ATLA;
        endcase
    end

    // State, PC, target and buffer registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum_r  <= ATLA;
            adres_r  <= {RESET_PS[31:2], 2'b00};
            hedef_r  <= {RESET_PS[31:1], 1'b0};
            tampon_r <= '0;
            bosluk_r <= 1'b0;
            yanlis_r <= 1'b0;
        end else begin
            durum_r  <= durum_d;
            bosluk_r <= teslim && ps_durdur_i;
            if (atlama_gecerli_i) begin
                hedef_r  <= {atlama_ps_i[31:1], 1'b0};
                tampon_r <= '0;
            end else if (durum_r == BEKLE && bellek_veri_gecerli_i) begin
                tampon_r <= bellek_veri_i;
            end
            if (durum_r == ATLA) begin
                adres_r  <= {hedef_r[31:2], 2'b00};
                yanlis_r <= hedef_r[1];
            end else if (teslim) begin
                adres_r  <= adres_r + 32'd4;
                yanlis_r <= 1'b0;
            end
        end
    end

    // Outputs read zero for as long as reset is held.
    assign bellek_istek_o = rst_i & istek_c;
    assign bellek_adres_o = rst_i ? adres_c  : '0;
    assign kuyruk_aktif_o = rst_i & aktif_c;
    assign ps_atladi_o    = rst_i & atladi_c;
    assign ps_o           = rst_i ? ps_c     : '0;
    assign buyruk_o       = rst_i ? buyruk_c : '0;

endmodule

// File: tb/tb_buyruk_getirici.sv
// Bench for buyruk_getirici: a randomized memory responder plus a
// transaction-level model of the fetch stream (expected PC, word and request
// address after each redirect), checked at every falling clock edge.
module tb_buyruk_getirici;

    localparam logic [31:0] RPS = 32'h0000_0100;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        atlama_gecerli_i, durdur_i, ps_durdur_i, ps_iki_artir_i;
    logic [31:0] atlama_ps_i;
    logic        bellek_istek_o, bellek_hazir_i, bellek_veri_gecerli_i;
    logic [31:0] bellek_adres_o, bellek_veri_i;
    logic        kuyruk_aktif_o, ps_atladi_o;
    logic [31:0] ps_o, buyruk_o;

    always #5 clk_i = ~clk_i;

    buyruk_getirici #(.RESET_PS(RPS)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .atlama_gecerli_i(atlama_gecerli_i), .atlama_ps_i(atlama_ps_i),
        .durdur_i(durdur_i), .ps_durdur_i(ps_durdur_i), .ps_iki_artir_i(ps_iki_artir_i),
        .bellek_istek_o(bellek_istek_o), .bellek_adres_o(bellek_adres_o),
        .bellek_hazir_i(bellek_hazir_i), .bellek_veri_gecerli_i(bellek_veri_gecerli_i),
        .bellek_veri_i(bellek_veri_i), .kuyruk_aktif_o(kuyruk_aktif_o),
        .ps_atladi_o(ps_atladi_o), .ps_o(ps_o), .buyruk_o(buyruk_o)
    );

    int checks = 0, errors = 0;

    // model of the architectural fetch stream
    logic [31:0] pend_tgt, exp_addr, exp_req;
    bit          pend_v, exp_mis, last_gap;
    int          held, n_deliv, n_puls, cyc;
    logic [31:0] dlog[$], plog[$], rlog[$];
    int          dcyc[$], pcyc[$];

    typedef struct { logic [31:0] a; int rdy; } mreq_t;
    mreq_t mq[$];

    // stimulus knobs
    int p_hazir, p_durdur, p_psd, lat_fix;
    bit rnd_redir, iki_mode, stall_hold, atl_req;
    logic [31:0] atl_tgt;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
        end
    endtask

    // Compare process: all DUT outputs against the model, once per cycle.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            chk({bellek_istek_o, kuyruk_aktif_o, ps_atladi_o} == 3'b000 && ps_o == 0 &&
                buyruk_o == 0 && bellek_adres_o == 0, "reset_outputs", ps_o, 32'h0);
        end else begin
            cyc++;
            chk(!(ps_atladi_o && kuyruk_aktif_o), "pulse_and_deliver", {31'd0, kuyruk_aktif_o}, 32'h0);
            if (ps_atladi_o) begin
                chk(pend_v && ps_o == pend_tgt, "redirect_ps", ps_o, pend_tgt);
                pend_v   = 1'b0;
                exp_addr = {pend_tgt[31:2], 2'b00};
                exp_mis  = pend_tgt[1];
                exp_req  = exp_addr;
                held     = 0;
                n_puls++;
                plog.push_back(ps_o);
                pcyc.push_back(cyc);
            end
            if (kuyruk_aktif_o) begin
                chk(!pend_v && !durdur_i && !last_gap, "deliver_legal",
                    {29'd0, pend_v, durdur_i, last_gap}, 32'h0);
                chk(ps_o == (exp_addr | (exp_mis ? 32'h2 : 32'h0)), "deliver_ps", ps_o,
                    exp_addr | (exp_mis ? 32'h2 : 32'h0));
                chk(buyruk_o == memf(exp_addr), "deliver_word", buyruk_o, memf(exp_addr));
                dlog.push_back(ps_o);
                dcyc.push_back(cyc);
                exp_addr += 32'd4;
                exp_mis  = 1'b0;
                held--;
                n_deliv++;
            end
            last_gap = kuyruk_aktif_o && ps_durdur_i;
            if (bellek_istek_o) begin
                chk(bellek_adres_o[1:0] == 2'b00 && mq.size() == 0, "req_protocol",
                    bellek_adres_o, {bellek_adres_o[31:2], 2'b00});
                chk(pend_v || kuyruk_aktif_o || held <= 0, "req_while_buffered", held, 32'h0);
                if (bellek_hazir_i) begin
                    if (!pend_v) begin
                        chk(bellek_adres_o == exp_req, "req_addr", bellek_adres_o, exp_req);
                        rlog.push_back(bellek_adres_o);
                        exp_req += 32'd4;
                    end
                    mq.push_back('{a: bellek_adres_o,
                                   rdy: cyc + ((lat_fix > 0) ? lat_fix : int'($urandom_range(3, 1)))});
                end
            end
            if (bellek_veri_gecerli_i && mq.size() > 0) begin
                void'(mq.pop_front());
                held++;
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
        atlama_gecerli_i = 1'b0;
        if (atl_req) begin
            atlama_gecerli_i = 1'b1;
            atlama_ps_i      = atl_tgt;
            pend_tgt         = {atl_tgt[31:1], 1'b0};
            pend_v           = 1'b1;
            atl_req          = 1'b0;
        end else if (rnd_redir && !ps_atladi_o && $urandom_range(99) < 3) begin
            atlama_gecerli_i = 1'b1;
            atlama_ps_i      = $urandom;
            pend_tgt         = {atlama_ps_i[31:1], 1'b0};
            pend_v           = 1'b1;
        end
        durdur_i       = stall_hold || ($urandom_range(99) < p_durdur);
        bellek_hazir_i = $urandom_range(99) < p_hazir;
        ps_durdur_i    = $urandom_range(99) < p_psd;
        ps_iki_artir_i = exp_mis && (iki_mode || $urandom_range(1) == 1);
        if (mq.size() > 0 && cyc + 1 >= mq[0].rdy) begin
            bellek_veri_gecerli_i = 1'b1;
            bellek_veri_i         = memf(mq[0].a);
        end else begin
            bellek_veri_gecerli_i = 1'b0;
            bellek_veri_i         = $urandom;
        end
    endtask

    task automatic cyc1();
        step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic wait_deliv(input int n, input int maxc);
        int tgt, i;
        tgt = n_deliv + n;
        i   = 0;
        while (n_deliv < tgt && i < maxc) begin cyc1(); i++; end
        chk(n_deliv >= tgt, "deliver_timeout", n_deliv, tgt);
    endtask

    task automatic wait_pulse(input int tgt, input int maxc);
        int i;
        i = 0;
        while (n_puls < tgt && i < maxc) begin cyc1(); i++; end
        chk(n_puls >= tgt, "pulse_timeout", n_puls, tgt);
    endtask

    task automatic idle_inputs();
        atlama_gecerli_i = 0; atlama_ps_i = 0; durdur_i = 0; ps_durdur_i = 0;
        ps_iki_artir_i = 0; bellek_hazir_i = 0; bellek_veri_gecerli_i = 0; bellek_veri_i = 0;
    endtask

    initial begin
        int rb, pb, d0;
        idle_inputs();
        pend_tgt = RPS; pend_v = 1; held = 0; last_gap = 0; exp_mis = 0;
        exp_addr = 0; exp_req = 0; n_deliv = 0; n_puls = 0; cyc = 0;
        atl_req = 0; atl_tgt = 0; stall_hold = 0; rnd_redir = 0; iki_mode = 0;
        p_hazir = 100; p_durdur = 0; p_psd = 100; lat_fix = 1;
        repeat (3) @(posedge clk_i);

        // reset release: jump pulse to RESET_PS, 1-cycle memory, drain slots
        step(); rst_i = 1'b1; @(negedge clk_i); #1;
        wait_deliv(2, 20);
        lat_fix = 3; p_psd = 0;
        wait_deliv(1, 20);
        chk(plog[0] == 32'h100, "t1_pulse_ps", plog[0], 32'h100);
        chk(dlog[0] == 32'h100, "t1_first_ps", dlog[0], 32'h100);
        chk(dlog[1] == 32'h104, "t1_second_ps", dlog[1], 32'h104);
        chk(dlog[2] == 32'h108, "t2_after_gap_ps", dlog[2], 32'h108);
        chk(dcyc[0] - pcyc[0] == 3, "t1_latency", dcyc[0] - pcyc[0], 32'd3);
        chk(dcyc[2] - dcyc[1] == 2, "t1_throughput", dcyc[2] - dcyc[1], 32'd2);

        // redirect to a misaligned target while 0x10C is outstanding
        atl_req = 1; atl_tgt = 32'h2002; iki_mode = 1;
        cyc1();
        lat_fix = 1; rb = rlog.size(); d0 = dlog.size();
        wait_pulse(2, 20);
        wait_deliv(2, 20);
        chk(plog[1] == 32'h2002, "t3_pulse_ps", plog[1], 32'h2002);
        chk(rlog[rb] == 32'h2000, "t3_req_addr", rlog[rb], 32'h2000);
        chk(dlog[d0] == 32'h2002, "t3_first_ps", dlog[d0], 32'h2002);
        chk(dlog[d0 + 1] == 32'h2004, "t3_second_ps", dlog[d0 + 1], 32'h2004);
        iki_mode = 0;

        // backend stall with a word buffered
        cyc1();
        stall_hold = 1;
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            chk(!kuyruk_aktif_o && !bellek_istek_o, "t4_stall_quiet",
                {30'd0, kuyruk_aktif_o, bellek_istek_o}, 32'h0);
            @(negedge clk_i); #1;
        end
        stall_hold = 0;
        wait_deliv(1, 10);
        chk(dlog[dlog.size() - 1] == 32'h2008, "t4_release_ps", dlog[dlog.size() - 1], 32'h2008);

        // redirect on a delivery cycle, then two redirects around IPTAL
        cyc1();
        pb = n_puls;
        atl_req = 1; atl_tgt = 32'h3000;
        step(); #1;
        chk(!kuyruk_aktif_o, "t5_suppressed", {31'd0, kuyruk_aktif_o}, 32'h0);
        @(negedge clk_i); #1;
        wait_pulse(pb + 1, 10);
        lat_fix = 4;
        cyc1();
        atl_req = 1; atl_tgt = 32'h4000; cyc1();
        atl_req = 1; atl_tgt = 32'h5006; cyc1();
        lat_fix = 1;
        wait_deliv(1, 30);
        chk(n_puls - pb == 2, "t5_pulse_count", n_puls - pb, 32'd2);
        chk(plog[plog.size() - 1] == 32'h5006, "t5_last_target", plog[plog.size() - 1], 32'h5006);
        chk(dlog[dlog.size() - 1] == 32'h5006, "t5_first_ps", dlog[dlog.size() - 1], 32'h5006);

        // address wrap at the top of memory
        atl_req = 1; atl_tgt = 32'hFFFF_FFF8; cyc1();
        wait_pulse(n_puls + 1, 20);
        wait_deliv(3, 30);
        chk(dlog[dlog.size() - 2] == 32'hFFFF_FFFC, "t6_top_ps", dlog[dlog.size() - 2], 32'hFFFF_FFFC);
        chk(dlog[dlog.size() - 1] == 32'h0, "t6_wrap_ps", dlog[dlog.size() - 1], 32'h0);
        chk(rlog[rlog.size() - 2] == 32'h0, "t6_wrap_req", rlog[rlog.size() - 2], 32'h0);

        // asynchronous reset while waiting for data
        lat_fix = 3;
        wait_deliv(1, 20);
        step(); #2;
        rst_i = 1'b0;
        #1;
        chk(!bellek_istek_o && !kuyruk_aktif_o && !ps_atladi_o && ps_o == 0 && buyruk_o == 0,
            "t6_async_reset", ps_o, 32'h0);
        idle_inputs();
        mq.delete();
        pend_tgt = RPS; pend_v = 1; held = 0; last_gap = 0; lat_fix = 1;
        repeat (3) @(posedge clk_i);
        d0 = dlog.size();
        step(); rst_i = 1'b1; @(negedge clk_i); #1;
        wait_deliv(2, 20);
        chk(dlog[d0] == 32'h100, "t6_restart_ps", dlog[d0], 32'h100);
        chk(dlog[d0 + 1] == 32'h104, "t6_restart_next", dlog[d0 + 1], 32'h104);

        // randomized traffic
        p_hazir = 60; p_durdur = 25; p_psd = 30; lat_fix = 0; rnd_redir = 1;
        d0 = n_deliv;
        for (int i = 0; i < 3000; i++) cyc1();
        chk(n_deliv - d0 > 100, "random_progress", n_deliv - d0, 32'd100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
